// File: rtl/pc_gen_bpred.sv
// pc_gen_bpred: fetch PC register with a direct-mapped BTB and 2-bit counter branch prediction
module pc_gen_bpred #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W = $clog2(BTB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic             btb_v   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag [BTB_ENTRIES];
  logic [XLEN-3:0]  btb_tgt [BTB_ENTRIES];
  logic [1:0]       btb_ctr [BTB_ENTRIES];
  logic [IDX_W-1:0] li, ui;
  logic             hit, uhit;
  logic [1:0]       uc, uc_next;
  logic [XLEN-1:0]  seq_pc;
  logic             unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};
  always_comb begin
    li          = pc[IDX_W+1:2];
    ui          = upd_pc[IDX_W+1:2];
    seq_pc      = pc + XLEN'(4);
    hit         = btb_v[li] && btb_tag[li] == pc[XLEN-1:IDX_W+2];
    uhit        = btb_v[ui] && btb_tag[ui] == upd_pc[XLEN-1:IDX_W+2];
    pred_taken  = hit && btb_ctr[li][1];
    pred_target = hit ? {btb_tgt[li], 2'b00} : seq_pc;
    uc          = btb_ctr[ui];
    uc_next     = upd_taken ? (&uc ? uc : uc + 2'd1) : (|uc ? uc - 2'd1 : uc);
  end
  // Lookup reads pre-update contents; a same-cycle update is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_v[i]   <= 1'b0;
        btb_ctr[i] <= 2'b01;
      end
    end else begin
      if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (pc_write) pc <= pred_taken ? pred_target : seq_pc;
      if (upd_valid && uhit) begin
        btb_ctr[ui] <= uc_next;
        if (upd_taken) btb_tgt[ui] <= upd_target[XLEN-1:2];
      end else if (upd_valid && upd_taken) begin
        btb_v[ui]   <= 1'b1;
        btb_tag[ui] <= upd_pc[XLEN-1:IDX_W+2];
        btb_tgt[ui] <= upd_target[XLEN-1:2];
        btb_ctr[ui] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_pc_gen_bpred.sv
// tb_pc_gen_bpred: directed and random checks of pc_gen_bpred against a behavioural model
module tb_pc_gen_bpred;
  logic        clk = 0;
  logic        rst = 1, pc_write = 0, redirect_valid = 0, upd_valid = 0, upd_taken = 0;
  logic [31:0] redirect_pc = 0, upd_pc = 0, upd_target = 0;
  logic [31:0] pc, pred_target;
  logic        pred_taken;
  int total = 0, bad = 0;
  bit chk_en = 0;

  pc_gen_bpred dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Behavioural model: 16-entry table indexed by word address mod 16, tag = addr / 64
  logic [31:0] mpc;
  bit          mv   [16];
  logic [31:0] mtag [16];
  logic [31:0] mtgt [16];
  int          mctr [16];

  function automatic bit m_hit(logic [31:0] a);
    int i = int'((a >> 2) % 16);
    return mv[i] && mtag[i] == (a >> 6);
  endfunction
  function automatic bit m_pt(logic [31:0] a);
    return m_hit(a) && mctr[int'((a >> 2) % 16)] >= 2;
  endfunction
  function automatic logic [31:0] m_ptgt(logic [31:0] a);
    return m_hit(a) ? mtgt[int'((a >> 2) % 16)] : a + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mpc = 32'h0;
      for (int i = 0; i < 16; i++) begin mv[i] = 0; mctr[i] = 1; end
    end else begin
      logic [31:0] nxt;
      int j;
      if (redirect_valid) nxt = redirect_pc & ~32'h3;
      else if (!pc_write) nxt = mpc;
      else if (m_pt(mpc)) nxt = m_ptgt(mpc);
      else nxt = mpc + 32'd4;
      j = int'((upd_pc >> 2) % 16);
      if (upd_valid && m_hit(upd_pc)) begin
        if (upd_taken) begin
          mctr[j] = mctr[j] < 3 ? mctr[j] + 1 : 3;
          mtgt[j] = upd_target & ~32'h3;
        end else mctr[j] = mctr[j] > 0 ? mctr[j] - 1 : 0;
      end else if (upd_valid && upd_taken) begin
        mv[j] = 1; mtag[j] = upd_pc >> 6; mtgt[j] = upd_target & ~32'h3; mctr[j] = 2;
      end
      mpc = nxt;
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", pc, mpc);
      chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, m_pt(mpc)});
      if (pred_taken === 1'b1 || m_pt(mpc)) chk("model_pred_target", pred_target, m_ptgt(mpc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    redirect_valid = 0; upd_valid = 0;
  endtask

  task automatic redir(logic [31:0] a);
    redirect_valid = 1; redirect_pc = a;
  endtask

  task automatic upd(logic [31:0] a, logic t, logic [31:0] tg);
    upd_valid = 1; upd_pc = a; upd_taken = t; upd_target = tg;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom % 8 == 0) return $urandom;
    return (($urandom % 4) << 6) | (($urandom % 4) << 2) | ($urandom % 4);
  endfunction

  // Counter walk at pc=0x40 (stalled): {taken, expected pred_taken after the update}
  bit walk_t [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
  bit walk_p [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    tick(); tick();
    chk_en = 1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pred", {31'd0, pred_taken}, 32'd0);
    rst = 0; pc_write = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("seq_pc", pc, 32'(4 * k));
      chk("seq_pred", {31'd0, pred_taken}, 32'd0);
    end
    pc_write = 0; tick();
    chk("stall_hold", pc, 32'h10);
    redir(32'h203); tick(); idle();
    chk("stall_redirect", pc, 32'h200);
    tick();
    chk("stall_after_redirect", pc, 32'h200);
    pc_write = 1; upd(32'h40, 1, 32'h100); tick(); idle();
    redir(32'h40); tick(); idle();
    chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target, 32'h100);
    tick();
    chk("alloc_follow", pc, 32'h100);
    pc_write = 0; redir(32'h40); tick(); idle();
    for (int k = 0; k < 9; k++) begin
      upd(32'h40, walk_t[k], k == 6 ? 32'h123 : 32'h100); tick(); idle();
      chk("ctr_walk", {31'd0, pred_taken}, {31'd0, walk_p[k]});
    end
    chk("hit_target_update", pred_target, 32'h120);
    upd(32'h440, 1, 32'h300); tick(); idle();
    chk("alias_evict", {31'd0, pred_taken}, 32'd0);
    chk("alias_evict_tgt", pred_target, 32'h44);
    redir(32'h440); tick(); idle();
    chk("alias_hit", {31'd0, pred_taken}, 32'd1);
    chk("alias_tgt", pred_target, 32'h300);
    upd(32'h80, 0, 32'h500); tick(); idle();
    chk("nt_miss_keeps", {31'd0, pred_taken}, 32'd1);
    redir(32'h80); tick(); idle();
    chk("nt_no_alloc", {31'd0, pred_taken}, 32'd0);
    redir(32'h440); tick(); idle();
    pc_write = 1; upd(32'h440, 0, 32'h0); tick(); idle();
    chk("collision_old_pred", pc, 32'h300);
    pc_write = 0; redir(32'h440); tick(); idle();
    chk("collision_new_state", {31'd0, pred_taken}, 32'd0);
    pc_write = 1; redir(32'hFFFF_FFFC); tick(); idle();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", pc, 32'h0);
    tick(); tick();
    rst = 1; redir(32'h40); upd(32'h40, 1, 32'h100); tick(); idle();
    rst = 0;
    chk("midreset_pc", pc, 32'h0);
    pc_write = 0; redir(32'h440); tick(); idle();
    chk("midreset_empty_440", {31'd0, pred_taken}, 32'd0);
    redir(32'h40); tick(); idle();
    chk("midreset_empty_40", {31'd0, pred_taken}, 32'd0);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom % 64 == 0);
      pc_write = ($urandom % 4 != 0);
      redirect_valid = ($urandom % 8 == 0);
      redirect_pc = rnd_addr();
      upd_valid = ($urandom % 3 == 0);
      upd_pc = ($urandom % 3 == 0) ? mpc : rnd_addr();
      upd_taken = ($urandom % 3 != 0);
      upd_target = $urandom;
      tick();
    end
    rst = 0; idle();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
